// File: rtl/player_motion_ctrl_if.sv
// Bundle between the key decoder / collision logic and the player-car motion
// controller. The master side drives frame timing, keys and collision; the
// slave side (the controller) returns sprite position, speed and crash status.
interface player_motion_ctrl_if #(
  parameter int SPEED_W = 4
);
  logic                startOfFrame;
  logic                move_r_key;
  logic                move_l_key;
  logic                accel_key;
  logic                brake_key;
  logic                collision;
  logic signed [10:0]  topLeftX;
  logic signed [10:0]  topLeftY;
  logic [SPEED_W-1:0]  scrollSpeed;
  logic                crashed;
  logic                crashPulse;
  logic                visible;

  modport master (
    output startOfFrame, move_r_key, move_l_key, accel_key, brake_key, collision,
    input  topLeftX, topLeftY, scrollSpeed, crashed, crashPulse, visible
  );

  modport slave (
    input  startOfFrame, move_r_key, move_l_key, accel_key, brake_key, collision,
    output topLeftX, topLeftY, scrollSpeed, crashed, crashPulse, visible
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player-car motion controller: gear (speed) from accelerate/brake keys,
// steering while moving, border/collision crash with a timed blinking CRASH
// state, and a one-clk crash event. All outputs come straight from flops.
module player_motion_ctrl #(
  parameter int INITIAL_X    = 303,
  parameter int INITIAL_Y    = 400,
  parameter int OBJ_W        = 32,
  parameter int BORDER_L     = 215,
  parameter int BORDER_R     = 399,
  parameter int MARGIN       = 2,
  parameter int X_SPEED      = 2,
  parameter int MAX_SPEED    = 8,
  parameter int SPEED_W      = 4,
  parameter int ACCEL_FRAMES = 4,
  parameter int CRASH_FRAMES = 90,
  parameter int BLINK_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  player_motion_ctrl_if.slave  bus
);

  localparam int ACC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int CNT_W = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;

  // Position math is done in 12-bit signed so X +/- step can never wrap.
  localparam logic signed [11:0] X_INIT = 12'(INITIAL_X);
  localparam logic signed [11:0] X_STEP = 12'(X_SPEED);
  localparam logic signed [11:0] X_MIN  = 12'(BORDER_L + MARGIN);
  localparam logic signed [11:0] X_MAX  = 12'(BORDER_R - MARGIN - OBJ_W);

  localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(MAX_SPEED);
  localparam logic [ACC_W-1:0]   ACC_LAST   = ACC_W'(ACCEL_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CRASH_LAST = CNT_W'(CRASH_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, CRASH} state_t;

  state_t               state_q, state_n;
  logic signed [11:0]   x_q, x_n;
  logic [SPEED_W-1:0]   speed_q, speed_n;
  logic [ACC_W-1:0]     acc_q, acc_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic                 crashed_q, crashed_n;
  logic                 pulse_q, pulse_n;
  logic                 visible_q, visible_n;
  logic                 border_hit;

  // State and registered outputs; asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values computed by the combinational block, independent of order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      x_q       <= X_INIT;
      speed_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      crashed_q <= 1'b0;
      pulse_q   <= 1'b0;
      visible_q <= 1'b1;
    end else begin
      state_q   <= state_n;
      x_q       <= x_n;
      speed_q   <= speed_n;
      acc_q     <= acc_n;
      cnt_q     <= cnt_n;
      crashed_q <= crashed_n;
      pulse_q   <= pulse_n;
      visible_q <= visible_n;
    end
  end

  // Next-state, gear, steering, crash timer and blink decode.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n    = state_q;
    x_n        = x_q;
    speed_n    = speed_q;
    acc_n      = acc_q;
    cnt_n      = cnt_q;
    pulse_n    = 1'b0;
    border_hit = 1'b0;

    case (state_q)
      IDLE: begin
        x_n     = X_INIT;
        speed_n = '0;
        acc_n   = '0;
        cnt_n   = '0;
        if (bus.startOfFrame) state_n = MOVE;
      end

      MOVE: begin
        if (bus.collision) begin
          state_n = CRASH;
        end else if (bus.startOfFrame) begin
          // Gear: brake beats accel; accel needs ACCEL_FRAMES held frames per step.
          if (bus.brake_key) begin
            speed_n = (speed_q == '0) ? '0 : speed_q - 1'b1;
            acc_n   = '0;
          end else if (bus.accel_key) begin
            if (acc_q == ACC_LAST) begin
              acc_n = '0;
              if (speed_q != SPD_MAX) speed_n = speed_q + 1'b1;
            end else begin
              acc_n = acc_q + 1'b1;
            end
          end else begin
            acc_n = '0;
          end

          // Steering uses the speed from before this frame's gear change.
          if ((speed_q != '0) && (bus.move_r_key ^ bus.move_l_key)) begin
            if (bus.move_r_key) begin
              if (x_q + X_STEP > X_MAX) border_hit = 1'b1;
              else                      x_n = x_q + X_STEP;
            end else begin
              if (x_q - X_STEP < X_MIN) border_hit = 1'b1;
              else                      x_n = x_q - X_STEP;
            end
          end

          if (border_hit) begin
            state_n = CRASH;
            x_n     = x_q;
          end
        end

        if (state_n == CRASH) begin
          speed_n = '0;
          acc_n   = '0;
          cnt_n   = '0;
          pulse_n = 1'b1;
        end
      end

      CRASH: begin
        speed_n = '0;
        if (bus.startOfFrame) begin
          if (cnt_q == CRASH_LAST) begin
            state_n = IDLE;
            x_n     = X_INIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    crashed_n = (state_n == CRASH);
    visible_n = (state_n != CRASH) ||
                (((32'(cnt_n) / 32'(BLINK_FRAMES)) % 32'd2) == 32'd0);
  end

  assign bus.topLeftX    = x_q[10:0];
  assign bus.topLeftY    = 11'(INITIAL_Y);
  assign bus.scrollSpeed = speed_q;
  assign bus.crashed     = crashed_q;
  assign bus.crashPulse  = pulse_q;
  assign bus.visible     = visible_q;

endmodule

// File: doc/player_motion_ctrl.md
# player_motion_ctrl

Parametrised player-car motion controller for the road-fighter VGA datapath. It sits between the key decoder and the player sprite's draw/collision logic, and outputs the sprite top-left position each frame. It adds several behaviours: a speed gear driven by accelerate/brake keys, steering that works only while moving, a crash state of configurable frame length with sprite blinking, and a single-cycle crash event for the score/sound blocks.

## Interface
Parameters:
- INITIAL_X, 303, respawn/reset X of the sprite top-left.
- INITIAL_Y, 400, fixed Y of the sprite top-left.
- OBJ_W, 32, sprite width in pixels.
- BORDER_L, 215, left road edge (pixels).
- BORDER_R, 399, right road edge (pixels).
- MARGIN, 2, safety gap to each edge.
- X_SPEED, 2, lateral pixels per frame while steering.
- MAX_SPEED, 8, top gear value; must be ≤ 2^SPEED_W − 1.
- SPEED_W, 4, width of scrollSpeed.
- ACCEL_FRAMES, 4, frames of held accelerate needed per +1 speed step.
- CRASH_FRAMES, 90, frames spent in CRASH.
- BLINK_FRAMES, 8, half-period of the blink, in frames.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset; asynchronous, active-low.
- startOfFrame  in  1  one-clk pulse per video frame.
- move_r_key, move_l_key  in  1 each  steer keys, level-sensitive.
- accel_key, brake_key  in  1 each  gear keys, level-sensitive.
- collision  in  1  sprite hit another object; sampled every clk.
- topLeftX, topLeftY  out  11 signed each  sprite position.
- scrollSpeed  out  SPEED_W  current speed, consumed by the road scroller.
- crashed  out  1  high while in CRASH.
- crashPulse  out  1  one-clk crash event.
- visible  out  1  sprite draw enable (blink).

## Operation
- Limits: X_MIN = BORDER_L + MARGIN and X_MAX = BORDER_R − MARGIN − OBJ_W. Defaults give 217 and 365.
- States are IDLE, MOVE and CRASH. All outputs and state are registered.
- IDLE:
  - X = INITIAL_X, Y = INITIAL_Y, speed = 0, accel counter = 0.
  - On startOfFrame, go to MOVE.
- MOVE, collision priority (evaluated every clk):
  - If collision = 1, go to CRASH. This overrides keys and startOfFrame in the same clk.
- MOVE, on each startOfFrame without collision, gear first:
  - brake_key = 1: speed −1, saturating at 0, and accel counter cleared. Brake wins over accel.
  - Else accel_key = 1: accel counter +1. When the counter reaches ACCEL_FRAMES − 1, speed +1 (saturating at MAX_SPEED) and the counter is cleared.
  - Else: speed held and accel counter cleared.
- MOVE, steering on the same startOfFrame:
  - Uses the pre-update speed. Ignored when speed = 0 or when both steer keys are high.
  - Right: if X + X_SPEED > X_MAX, go to CRASH with X unchanged. Otherwise X += X_SPEED.
  - Left: if X − X_SPEED < X_MIN, go to CRASH with X unchanged. Otherwise X −= X_SPEED.
- CRASH:
  - Speed forced to 0. Position frozen. collision and all keys ignored.
  - Frame counter cleared on entry and incremented on each startOfFrame.
  - On the startOfFrame where the counter equals CRASH_FRAMES − 1, go to IDLE.
  - visible = 1 when (counter / BLINK_FRAMES) is even, otherwise 0. visible = 1 in all other states.
- Arithmetic: position math in 12-bit signed to avoid wrap. Outputs are truncated to 11 bits; all parameter combinations must keep X within 0..1023.

## Timing
- Reset values: topLeftX = INITIAL_X, topLeftY = INITIAL_Y, scrollSpeed = 0, crashed = 0, crashPulse = 0, visible = 1, state = IDLE, all counters 0.
- Reset mid-operation, in any state, returns to these values asynchronously.
- Position and speed update one clk after the qualifying startOfFrame edge.
- crashed rises one clk after the collision or border-hit clk.
- crashPulse is high for exactly that first CRASH clk.
- CRASH lasts exactly CRASH_FRAMES startOfFrame pulses.
- After IDLE, MOVE is entered on the next startOfFrame, so normal motion resumes one frame later.
- Collision held continuously through and after CRASH re-crashes on the first MOVE clk.

## Test plan
- Reset, then 1 SOF, then hold accel_key for 8 SOFs → scrollSpeed 0→1 after SOF 4, 1→2 after SOF 8. Hold 40 more → saturates at 8.
- Speed 2, hold move_r_key for 10 SOFs → topLeftX 303→323 in +2 steps. Both keys held → X unchanged. Speed 0 with move_l_key → X unchanged.
- Speed ≥ 1, steer right from X = 363 → X = 365 on SOF 1. On SOF 2, crashPulse = 1 for one clk, crashed = 1, X stays 365, speed 0.
- collision pulse mid-frame in MOVE → crashed the next clk. Count 90 SOFs: visible pattern is 8 frames on, 8 off. After SOF 90, state is IDLE with X = 303. Next SOF: MOVE.
- accel and brake both held at speed 3 → speed 2, 1, 0, 0 on successive SOFs.
- resetN low during CRASH at frame 40 → immediate reset values, visible = 1, crashed = 0.
